// File: rtl/sr_dlt_pkg.sv
// Shared types and constants for the serial delay line tester.
package sr_dlt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    PROBE = 2'd2,
    PRBS  = 2'd3
  } state_e;

  // PRBS7 polynomial x^7 + x^6 + 1: feedback taps on register bits 6 and 5.
  localparam int         PRBS_TAP_HI = 6;
  localparam int         PRBS_TAP_LO = 5;
  localparam logic [6:0] PRBS_SEED   = 7'h7F;

  // Next PRBS7 bit predicted from the last seven bits (bit 6 is the oldest).
  function automatic logic prbs7_fb(input logic [6:0] s);
    return s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO];
  endfunction

endpackage

// File: rtl/sr_delay_line_tester_prbs7_checker.sv
// Self-synchronising PRBS7 checker: the first seven received bits seed the
// sync register, every later bit is compared against the bit they predict.
module prbs7_checker
  import sr_dlt_pkg::*;
#(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             rx_bit,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  logic [6:0]       sync_r;
  logic [2:0]       fill_r;
  logic             locked_r;
  logic [ERR_W-1:0] err_r;
  logic [6:0]       sync_next_s;

  // Saturating increment so a noisy line never wraps the error count.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

  assign sync_next_s = {sync_r[5:0], rx_bit};
  assign locked      = locked_r;
  assign err_cnt     = err_r;

  // Shift received bits in, decide lock after the seventh, then count mispredictions.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sync_r   <= 7'd0;
      fill_r   <= 3'd0;
      locked_r <= 1'b0;
      err_r    <= {ERR_W{1'b0}};
    end else if (bit_valid) begin
      sync_r <= sync_next_s;
      if (fill_r != 3'd7) begin
        fill_r <= fill_r + 3'd1;
        if (fill_r == 3'd6) begin
          // An all-zero seed can never resynchronise, so report it as fully broken.
          if (sync_next_s != 7'd0) begin
            locked_r <= 1'b1;
          end else begin
            err_r <= {ERR_W{1'b1}};
          end
        end
      end else if (rx_bit != prbs7_fb(sync_r)) begin
        err_r <= sat_inc(err_r);
      end
    end
  end

endmodule

// File: rtl/sr_delay_line_tester.sv
// Drives the on-chip delay line: flushes it, measures latency with a single
// probe pulse, then streams PRBS7 and counts errors on the returning data.
module sr_delay_line_tester
  import sr_dlt_pkg::*;
#(
  parameter int LAT_W     = 10,
  parameter int ERR_W     = 16,
  parameter int N_BITS    = 256,
  parameter int FLUSH_CYC = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             sr_in,
  input  logic             sr_out_fb,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             locked,
  output logic [LAT_W-1:0] latency,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int               CNT_W   = $clog2(N_BITS + 1);
  localparam int               FL_W    = $clog2(FLUSH_CYC + 1);
  localparam logic [LAT_W-1:0] LAT_MAX = {LAT_W{1'b1}};
  localparam logic [CNT_W-1:0] N_TOT   = CNT_W'(N_BITS);
  localparam logic [CNT_W-1:0] N_LAST  = CNT_W'(N_BITS - 1);
  localparam logic [FL_W-1:0]  FL_LAST = FL_W'(FLUSH_CYC - 1);

  state_e           state_r,   state_s;
  logic             sr_in_r,   sr_in_s;
  logic             busy_r,    busy_s;
  logic             done_r,    done_s;
  logic             timeout_r, timeout_s;
  logic [LAT_W-1:0] latency_r, latency_s;
  logic [FL_W-1:0]  fl_cnt_r,  fl_cnt_s;
  logic [LAT_W-1:0] lat_cnt_r, lat_cnt_s;
  logic [6:0]       tx_lfsr_r, tx_lfsr_s;
  logic [CNT_W-1:0] tx_cnt_r,  tx_cnt_s;
  logic [LAT_W-1:0] rx_dly_r,  rx_dly_s;
  logic [CNT_W-1:0] rx_cnt_r,  rx_cnt_s;
  logic [LAT_W-1:0] k_s;
  logic             ck_clear_s;
  logic             ck_valid_s;

  assign sr_in   = sr_in_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign timeout = timeout_r;
  assign latency = latency_r;

  // Next-state and next-output logic for the run sequencer.
  always_comb begin
    state_s    = state_r;
    sr_in_s    = sr_in_r;
    busy_s     = busy_r;
    done_s     = done_r;
    timeout_s  = timeout_r;
    latency_s  = latency_r;
    fl_cnt_s   = fl_cnt_r;
    lat_cnt_s  = lat_cnt_r;
    tx_lfsr_s  = tx_lfsr_r;
    tx_cnt_s   = tx_cnt_r;
    rx_dly_s   = rx_dly_r;
    rx_cnt_s   = rx_cnt_r;
    ck_clear_s = 1'b0;
    ck_valid_s = 1'b0;
    k_s        = lat_cnt_r + LAT_W'(1);
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s    = FLUSH;
          sr_in_s    = 1'b0;
          busy_s     = 1'b1;
          done_s     = 1'b0;
          timeout_s  = 1'b0;
          latency_s  = {LAT_W{1'b0}};
          fl_cnt_s   = {FL_W{1'b0}};
          lat_cnt_s  = {LAT_W{1'b0}};
          tx_lfsr_s  = PRBS_SEED;
          tx_cnt_s   = {CNT_W{1'b0}};
          rx_dly_s   = {LAT_W{1'b0}};
          rx_cnt_s   = {CNT_W{1'b0}};
          ck_clear_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      FLUSH: begin
        sr_in_s = 1'b0;
        if (fl_cnt_r == FL_LAST) begin
          sr_in_s   = 1'b1;
          lat_cnt_s = {LAT_W{1'b0}};
          state_s   = PROBE;
        end else begin
          fl_cnt_s = fl_cnt_r + FL_W'(1);
        end
      end
      PROBE: begin
        sr_in_s = 1'b0;
        if (sr_out_fb) begin
          // Hit: TX bit 0 goes out on this same edge; RX starts k edges later.
          latency_s = k_s;
          rx_dly_s  = lat_cnt_r;
          sr_in_s   = tx_lfsr_r[6];
          tx_lfsr_s = {tx_lfsr_r[5:0], prbs7_fb(tx_lfsr_r)};
          tx_cnt_s  = CNT_W'(1);
          state_s   = PRBS;
        end else if (k_s == LAT_MAX) begin
          latency_s = LAT_MAX;
          timeout_s = 1'b1;
          done_s    = 1'b1;
          busy_s    = 1'b0;
          state_s   = IDLE;
        end else begin
          lat_cnt_s = k_s;
        end
      end
      PRBS: begin
        if (tx_cnt_r != N_TOT) begin
          sr_in_s   = tx_lfsr_r[6];
          tx_lfsr_s = {tx_lfsr_r[5:0], prbs7_fb(tx_lfsr_r)};
          tx_cnt_s  = tx_cnt_r + CNT_W'(1);
        end else begin
          sr_in_s = 1'b0;
        end
        if (rx_dly_r != {LAT_W{1'b0}}) begin
          rx_dly_s = rx_dly_r - LAT_W'(1);
        end else begin
          ck_valid_s = 1'b1;
          if (rx_cnt_r == N_LAST) begin
            done_s  = 1'b1;
            busy_s  = 1'b0;
            sr_in_s = 1'b0;
            state_s = IDLE;
          end else begin
            rx_cnt_s = rx_cnt_r + CNT_W'(1);
          end
        end
      end
      default: begin
        state_s = IDLE;
        sr_in_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset returns everything to idle with outputs low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      sr_in_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      latency_r <= {LAT_W{1'b0}};
      fl_cnt_r  <= {FL_W{1'b0}};
      lat_cnt_r <= {LAT_W{1'b0}};
      tx_lfsr_r <= PRBS_SEED;
      tx_cnt_r  <= {CNT_W{1'b0}};
      rx_dly_r  <= {LAT_W{1'b0}};
      rx_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_s;
      sr_in_r   <= sr_in_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      timeout_r <= timeout_s;
      latency_r <= latency_s;
      fl_cnt_r  <= fl_cnt_s;
      lat_cnt_r <= lat_cnt_s;
      tx_lfsr_r <= tx_lfsr_s;
      tx_cnt_r  <= tx_cnt_s;
      rx_dly_r  <= rx_dly_s;
      rx_cnt_r  <= rx_cnt_s;
    end
  end

  prbs7_checker #(.ERR_W(ERR_W)) u_checker (
    .clk       (clk),
    .rst       (rst),
    .clear     (ck_clear_s),
    .bit_valid (ck_valid_s),
    .rx_bit    (sr_out_fb),
    .locked    (locked),
    .err_cnt   (err_cnt)
  );

endmodule
